// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// encoding, default width and the op decoder used by the datapath.
package mdu_iter_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [3:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_DIV   = 4'd2,
      OP_DIVU  = 4'd3,
      OP_MADD  = 4'd4,
      OP_MADDU = 4'd5,
      OP_MSUB  = 4'd6,
      OP_MSUBU = 4'd7,
      OP_MTHI  = 4'd8,
      OP_MTLO  = 4'd9
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

   typedef struct packed {
      logic arith;
      logic is_div;
      logic is_signed;
      logic acc;
      logic sub;
      logic mthi;
      logic mtlo;
   } op_dec_t;

   // Unknown codes decode to all-zero, which makes them a no-op.
   function automatic op_dec_t decode_op(input logic [3:0] op);
      op_dec_t d;
      d = '0;
      case (op)
         OP_MULT:  begin d.arith = 1'b1; d.is_signed = 1'b1; end
         OP_MULTU: begin d.arith = 1'b1; end
         OP_DIV:   begin d.arith = 1'b1; d.is_div = 1'b1; d.is_signed = 1'b1; end
         OP_DIVU:  begin d.arith = 1'b1; d.is_div = 1'b1; end
         OP_MADD:  begin d.arith = 1'b1; d.acc = 1'b1; d.is_signed = 1'b1; end
         OP_MADDU: begin d.arith = 1'b1; d.acc = 1'b1; end
         OP_MSUB:  begin d.arith = 1'b1; d.acc = 1'b1; d.sub = 1'b1; d.is_signed = 1'b1; end
         OP_MSUBU: begin d.arith = 1'b1; d.acc = 1'b1; d.sub = 1'b1; end
         OP_MTHI:  begin d.mthi = 1'b1; end
         OP_MTLO:  begin d.mtlo = 1'b1; end
         default:  d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/result bundle between a requester and the multiply/divide unit.
interface mdu_iter_if #(
   parameter int WIDTH = mdu_iter_pkg::MDU_WIDTH
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             dbz;

   modport master (
      output start, op, d1, d2,
      input  busy, hi, lo, dbz
   );

   modport slave (
      input  start, op, d1, d2,
      output busy, hi, lo, dbz
   );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-divide step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             in_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             unused_diff_bit;

   always_comb begin
      shifted  = {rem, in_bit};
      // Two guard bits so the top bit is a clean borrow even for a zero divisor.
      diff     = {1'b0, shifted} - {2'b00, divisor};
      q_bit    = ~diff[WIDTH+1];
      rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      unused_diff_bit = diff[WIDTH];
   end
endmodule

// File: rtl/mdu_iter.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, then a single fix-up cycle for sign and accumulate.
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic      clk,
   input  logic      reset,
   mdu_iter_if.slave bus
);
   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   mdu_state_e       state_reg, state_next;
   op_dec_t          dec_in;
   logic             arith_accept, busy;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] p_hi_reg, p_lo_reg, b_mag_reg, a_raw_reg;
   logic [WIDTH-1:0] hi_reg, lo_reg;
   logic [2*WIDTH-1:0] acc_base_reg;
   logic             a_neg_reg, b_neg_reg, b_zero_reg, dbz_reg;
   logic             div_op_reg, macc_reg, msub_reg;

   logic             a_neg_in, b_neg_in;
   logic [WIDTH-1:0] a_mag_in, b_mag_in;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] div_rem;
   logic             div_q;
   logic [WIDTH-1:0] quo_s, rem_s;
   logic [2*WIDTH-1:0] prod_s, fix_result;

   assign dec_in   = decode_op(bus.op);
   assign bus.busy = busy;
   assign bus.hi   = hi_reg;
   assign bus.lo   = lo_reg;
   assign bus.dbz  = dbz_reg;

   always_comb begin
      a_neg_in = dec_in.is_signed & bus.d1[WIDTH-1];
      b_neg_in = dec_in.is_signed & bus.d2[WIDTH-1];
      a_mag_in = a_neg_in ? -bus.d1 : bus.d1;
      b_mag_in = b_neg_in ? -bus.d2 : bus.d2;
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next   = state_reg;
      arith_accept = 1'b0;
      busy         = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            busy = 1'b0;
            if (bus.start && dec_in.arith) begin
               arith_accept = 1'b1;
               state_next   = ST_CALC;
            end
         end
         ST_CALC: if (cnt_reg == CNT_ONE) state_next = ST_FIX;
         ST_FIX:  state_next = ST_IDLE;
         default: begin
            state_next = ST_IDLE;
            busy       = 1'b0;
         end
      endcase
   end

   mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem      (p_hi_reg),
      .in_bit   (p_lo_reg[WIDTH-1]),
      .divisor  (b_mag_reg),
      .rem_next (div_rem),
      .q_bit    (div_q)
   );

   // Shift-add multiply: p_lo holds the remaining multiplier bits.
   assign mul_sum = {1'b0, p_hi_reg} + {1'b0, {WIDTH{p_lo_reg[0]}} & b_mag_reg};

   always_comb begin
      quo_s  = (a_neg_reg ^ b_neg_reg) ? -p_lo_reg : p_lo_reg;
      rem_s  = a_neg_reg ? -p_hi_reg : p_hi_reg;
      prod_s = (a_neg_reg ^ b_neg_reg) ? -{p_hi_reg, p_lo_reg} : {p_hi_reg, p_lo_reg};
      fix_result = prod_s;
      if (div_op_reg) begin
         if (b_zero_reg) fix_result = {a_raw_reg, {WIDTH{1'b1}}};
         else            fix_result = {rem_s, quo_s};
      end else if (macc_reg) begin
         fix_result = msub_reg ? (acc_base_reg - prod_s) : (acc_base_reg + prod_s);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg      <= '0;
         p_hi_reg     <= '0;
         p_lo_reg     <= '0;
         b_mag_reg    <= '0;
         a_raw_reg    <= '0;
         acc_base_reg <= '0;
         a_neg_reg    <= 1'b0;
         b_neg_reg    <= 1'b0;
         b_zero_reg   <= 1'b0;
         div_op_reg   <= 1'b0;
         macc_reg     <= 1'b0;
         msub_reg     <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         dbz_reg      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (arith_accept) begin
                  cnt_reg      <= CNT_LOAD;
                  p_hi_reg     <= '0;
                  p_lo_reg     <= a_mag_in;
                  b_mag_reg    <= b_mag_in;
                  a_raw_reg    <= bus.d1;
                  acc_base_reg <= {hi_reg, lo_reg};
                  a_neg_reg    <= a_neg_in;
                  b_neg_reg    <= b_neg_in;
                  b_zero_reg   <= (bus.d2 == '0);
                  div_op_reg   <= dec_in.is_div;
                  macc_reg     <= dec_in.acc;
                  msub_reg     <= dec_in.sub;
                  if (dec_in.is_div) dbz_reg <= 1'b0;
               end else if (bus.start && dec_in.mthi) begin
                  hi_reg <= bus.d1;
               end else if (bus.start && dec_in.mtlo) begin
                  lo_reg <= bus.d1;
               end
            end
            ST_CALC: begin
               cnt_reg <= cnt_reg - CNT_ONE;
               if (div_op_reg) begin
                  p_hi_reg <= div_rem;
                  p_lo_reg <= {p_lo_reg[WIDTH-2:0], div_q};
               end else begin
                  p_hi_reg <= mul_sum[WIDTH:1];
                  p_lo_reg <= {mul_sum[0], p_lo_reg[WIDTH-1:1]};
               end
            end
            ST_FIX: begin
               {hi_reg, lo_reg} <= fix_result;
               if (div_op_reg && b_zero_reg) dbz_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter with hand-computed HI/LO results.
module tb_mdu_iter;
   import mdu_iter_pkg::*;

   localparam int W = 32;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   mdu_iter_if #(.WIDTH(W)) bus ();

   mdu_iter #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = o;
      bus.d1    = a;
      bus.d2    = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.d1    = $urandom;
      bus.d2    = $urandom;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run(input string tag, input logic [3:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp);
      int n;
      issue(o, a, b);
      wait_done(n);
      chk({tag, ".lat"}, 64'(n), 64'd33);
      chk({tag, ".hilo"}, {bus.hi, bus.lo}, exp);
      $display("%-8s op=%0d d1=%h d2=%h busy_cycles=%0d hi=%h lo=%h dbz=%0b",
               tag, o, a, b, n, bus.hi, bus.lo, bus.dbz);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.d1    = '0;
      bus.d2    = '0;
      repeat (3) @(negedge clk);
      chk("rst.busy", {63'd0, bus.busy}, 64'd0);
      chk("rst.hilo", {bus.hi, bus.lo}, 64'd0);
      chk("rst.dbz", {63'd0, bus.dbz}, 64'd0);
      reset = 1'b0;

      run("mult", OP_MULT, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE);
      run("div", OP_DIV, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD);
      run("divu", OP_DIVU, 32'hFFFF_FFF9, 32'h2, 64'h0000_0001_7FFF_FFFC);
      run("divu0", OP_DIVU, 32'h1234, 32'h0, 64'h0000_1234_FFFF_FFFF);
      chk("divu0.dbz", {63'd0, bus.dbz}, 64'd1);
      run("div63", OP_DIV, 32'd6, 32'd3, 64'h0000_0000_0000_0002);
      chk("div63.dbz", {63'd0, bus.dbz}, 64'd0);

      issue(OP_MTHI, 32'd5, 32'd0);
      chk("mthi.hi", {32'd0, bus.hi}, 64'd5);
      chk("mthi.busy", {63'd0, bus.busy}, 64'd0);
      $display("mthi     hi=%h lo=%h", bus.hi, bus.lo);
      issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
      chk("mtlo.hilo", {bus.hi, bus.lo}, 64'h0000_0005_FFFF_FFFF);
      $display("mtlo     hi=%h lo=%h", bus.hi, bus.lo);

      run("maddu", OP_MADDU, 32'd1, 32'd1, 64'h0000_0006_0000_0000);
      run("msub", OP_MSUB, 32'd1, 32'd1, 64'h0000_0005_FFFF_FFFF);
      run("multneg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
      run("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run("divnegb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
      run("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      chk("divovf.dbz", {63'd0, bus.dbz}, 64'd0);
      run("madd", OP_MADD, 32'h8000_0000, 32'd2, 64'hFFFF_FFFF_8000_0000);

      issue(4'hF, 32'h1111_1111, 32'h2222_2222);
      chk("badop.busy", {63'd0, bus.busy}, 64'd0);
      @(negedge clk);
      chk("badop.hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_8000_0000);
      $display("badop    hi=%h lo=%h", bus.hi, bus.lo);

      // Requests while busy must be dropped.
      issue(OP_MULT, 32'd3, 32'd4);
      @(negedge clk);
      bus.start = 1'b1; bus.op = OP_DIVU; bus.d1 = 32'd100; bus.d2 = 32'd7;
      @(negedge clk);
      bus.op = OP_MTHI; bus.d1 = 32'hDEAD;
      @(negedge clk);
      bus.start = 1'b0;
      chk("ign.mthi", {32'd0, bus.hi}, 64'h0000_0000_FFFF_FFFF);
      wait_done(n);
      chk("ign.lat", 64'(n), 64'd30);
      chk("ign.hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_000C);
      $display("ignore   busy_cycles=%0d hi=%h lo=%h", n, bus.hi, bus.lo);

      run("divu0b", OP_DIVU, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF);
      chk("divu0b.dbz", {63'd0, bus.dbz}, 64'd1);

      // Reset on the tenth busy cycle aborts the multiply.
      issue(OP_MULT, 32'd3, 32'd4);
      repeat (10) @(negedge clk);
      chk("rstmid.busy_before", {63'd0, bus.busy}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid.busy", {63'd0, bus.busy}, 64'd0);
      chk("rstmid.hilo", {bus.hi, bus.lo}, 64'd0);
      chk("rstmid.dbz", {63'd0, bus.dbz}, 64'd0);
      $display("rstmid   busy=%0b hi=%h lo=%h dbz=%0b", bus.busy, bus.hi, bus.lo, bus.dbz);

      // Start on the very first edge after reset release.
      reset = 1'b0;
      bus.start = 1'b1; bus.op = OP_MULT; bus.d1 = 32'd6; bus.d2 = 32'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(n);
      chk("postrst.lat", 64'(n), 64'd33);
      chk("postrst.hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_002A);
      $display("postrst  busy_cycles=%0d hi=%h lo=%h", n, bus.hi, bus.lo);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand width; HI and LO are each WIDTH bits.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request to launch the operation on op; sampled only when busy=0.
REQ-005 op  in  4  operation code from the shared package: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO.
REQ-006 d1  in  WIDTH  operand A: dividend, multiplicand, or MTHI/MTLO data.
REQ-007 d2  in  WIDTH  operand B: divisor or multiplier.
REQ-008 busy  out  1  high while an arithmetic operation is in flight.
REQ-009 hi  out  WIDTH  HI register; for DIV/DIVU it holds the remainder.
REQ-010 lo  out  WIDTH  LO register; for DIV/DIVU it holds the quotient.
REQ-011 dbz  out  1  sticky divide-by-zero flag; cleared by reset or by the next accepted DIV/DIVU.

Function
REQ-012 FSM states IDLE, CALC and FIX; reset state is IDLE.
REQ-013 IDLE with start=1 and an arithmetic op: the block latches d1, d2, op and the current {hi,lo}, loads the step counter with WIDTH, and enters CALC; busy=1 from the next cycle.
REQ-014 IDLE with start=1 and MTHI/MTLO: the block writes d1 to hi or lo at that edge, stays IDLE, and busy stays 0.
REQ-015 CALC: one radix-2 step per cycle (shift-add multiply, restoring divide) on operand magnitudes; the counter decrements and the FSM moves to FIX when it reaches 0.
REQ-016 FIX, one cycle: sign correction, then MADD*/MSUB* add or subtract against the latched {hi,lo} modulo 2^(2*WIDTH); {hi,lo} is written and busy drops at the same edge, returning to IDLE.
REQ-017 Latency: busy is high for exactly WIDTH+1 cycles; results are visible the cycle busy=0, i.e. 33 cycles after acceptance for WIDTH=32.
REQ-018 Signed multiply: the full 2*WIDTH-bit two's-complement product; unsigned multiply: the zero-extended product.
REQ-019 Signed divide truncates toward zero; the remainder takes the sign of the dividend.
REQ-020 Divide by zero: lo is all ones, hi is d1, dbz=1, and full latency still applies.
REQ-021 Signed overflow (d1 = most-negative value, d2 = -1): lo = d1, hi = 0, dbz unchanged.
REQ-022 start, or MTHI/MTLO, while busy=1 is ignored with no effect on state, hi or lo.
REQ-023 Operand inputs may change after acceptance; the result depends only on the latched values.
REQ-024 An unknown op with start=1 in IDLE is a no-op.

Reset
REQ-025 reset=1 at an edge, including mid-operation, forces IDLE, busy=0, hi=0, lo=0, dbz=0 and counter=0, and discards any in-flight result.
REQ-026 The first start may be accepted on the first edge after reset is deasserted.

Structure
REQ-027 The op enumeration, state encoding and the WIDTH default belong in the shared package and are reused by the decoder.
REQ-028 One sub-module, mdu_div_step, holds the combinational restoring-divide step (partial remainder and quotient bit); the multiply step stays inline.
REQ-029 No behavioural * / or % operators appear in synthesised RTL.

Verification
REQ-030 MULT d1=0xFFFFFFFF, d2=0x00000002 -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-031 DIV d1=0xFFFFFFF9 (-7), d2=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU with the same operands -> lo=0x7FFFFFFC, hi=1.
REQ-032 DIVU d1=0x1234, d2=0 -> lo=0xFFFFFFFF, hi=0x1234, dbz=1; then DIV 6/3 -> lo=2, hi=0, dbz=0.
REQ-033 MTHI 5, MTLO 0xFFFFFFFF, then MADDU 1*1 -> hi=6, lo=0; then MSUB 1*1 -> hi=5, lo=0xFFFFFFFF.
REQ-034 Start MULT 3*4, assert reset on busy cycle 10 -> next cycle busy=0, hi=lo=0; a start issued while busy is ignored and the original result is unchanged.
